// File: rtl/aes128_codec.sv
// Iterative AES-128 encrypt/decrypt engine with valid/ready handshakes and an
// optional round-key cache; each round core returns one round per start pulse.
package aes128_pkg;
  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0
  function automatic logic [7:0] gf_inv(logic [7:0] x);
    logic [7:0] r, sq;
    r = 8'h01;
    sq = x;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      r = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] b, int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(logic [7:0] y);
    return gf_inv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] sub_bytes(logic [127:0] s, logic inv);
    logic [127:0] r;
    r = s;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = inv ? inv_sbox(s[8*i +: 8]) : sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Byte 4*c+row sits at bits [127-8*(4*c+row) -: 8]
  function automatic logic [127:0] shift_rows(logic [127:0] s, logic inv);
    logic [127:0] r;
    int src;
    r = s;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) begin
        src = inv ? (c - rw + 4) % 4 : (c + rw) % 4;
        r[127-8*(4*c+rw) -: 8] = s[127-8*(4*src+rw) -: 8];
      end
    return r;
  endfunction

  function automatic logic [127:0] mix_cols(logic [127:0] s, logic inv);
    logic [127:0] r;
    logic [31:0] cv;
    logic [7:0] a [4];
    logic [7:0] acc;
    r = s;
    cv = inv ? 32'h0e0b0d09 : 32'h02030101;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
      for (int rw = 0; rw < 4; rw++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[j], cv[31-8*((j-rw+4)%4) -: 8]);
        r[127-8*(4*c+rw) -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] next_key(logic [127:0] k, logic [7:0] rcon);
    logic [31:0] t, n0, n1, n2, n3;
    t = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rcon, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction
endpackage

module round_key_tf (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic         done_o,
  output logic [127:0] key_o
);
  import aes128_pkg::*;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_o <= 1'b0;
      key_o  <= '0;
    end else begin
      done_o <= start_i;
      if (start_i) key_o <= next_key(key_i, rcon_i);
    end
  end
endmodule

module round_tf (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         bypass_mc,
  input  logic [127:0] state_i,
  output logic         done_o,
  output logic [127:0] state_o
);
  import aes128_pkg::*;
  logic [127:0] ss;
  assign ss = shift_rows(sub_bytes(state_i, 1'b0), 1'b0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_o  <= 1'b0;
      state_o <= '0;
    end else begin
      done_o <= start_i;
      if (start_i) state_o <= bypass_mc ? ss : mix_cols(ss, 1'b0);
    end
  end
endmodule

// InvMixColumns runs first so that the key XOR done by the caller lines up
// with the forward schedule rk[9..0].
module inv_round_tf (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         bypass_mc,
  input  logic [127:0] state_i,
  output logic         done_o,
  output logic [127:0] state_o
);
  import aes128_pkg::*;
  logic [127:0] mc;
  assign mc = bypass_mc ? state_i : mix_cols(state_i, 1'b1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_o  <= 1'b0;
      state_o <= '0;
    end else begin
      done_o <= start_i;
      if (start_i) state_o <= sub_bytes(shift_rows(mc, 1'b1), 1'b1);
    end
  end
endmodule

module aes128_codec #(
  parameter int KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         decrypt_i,
  input  logic         key_load_i,
  input  logic [127:0] key_i,
  input  logic [127:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o,
  output logic         key_cached_o
);
  import aes128_pkg::*;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_KEY_EXP  = 3'd1;
  localparam logic [2:0] S_INIT_ARK = 3'd2;
  localparam logic [2:0] S_ROUND    = 3'd3;
  localparam logic [2:0] S_OUT      = 3'd4;

  logic [2:0]   fsm_reg;
  logic         dec_reg, cached_reg;
  logic [127:0] blk_reg, dout_reg;
  logic [127:0] rk_reg [0:10];
  logic [3:0]   kidx_reg, rnd_reg;
  logic [7:0]   rcon_reg;

  logic         accept, need_exp, kstart, kdone, cstart, edone, ddone, cdone, bypass;
  logic [127:0] kin, kout, cin, eout, dcore_out, cout, round_res;
  logic [3:0]   kx, nrnd;
  logic [7:0]   krcon;

  assign in_ready_o   = (fsm_reg == S_IDLE);
  assign out_valid_o  = (fsm_reg == S_OUT);
  assign data_o       = dout_reg;
  assign key_cached_o = (KEY_CACHE != 0) && cached_reg;

  assign accept   = in_valid_i && in_ready_o;
  assign need_exp = key_load_i || (KEY_CACHE == 0) || !cached_reg;

  // The first key step is launched straight from the accept cycle
  assign kstart = (accept && need_exp) ||
                  (fsm_reg == S_KEY_EXP && kdone && kidx_reg != 4'd10);
  assign kin    = (fsm_reg == S_IDLE) ? key_i : kout;
  assign krcon  = (fsm_reg == S_IDLE) ? 8'h01 : rcon_reg;

  assign cdone     = dec_reg ? ddone : edone;
  assign cout      = dec_reg ? dcore_out : eout;
  assign kx        = dec_reg ? (4'd10 - rnd_reg) : rnd_reg;
  assign round_res = cout ^ rk_reg[kx];
  assign cstart    = (fsm_reg == S_INIT_ARK) ||
                     (fsm_reg == S_ROUND && cdone && rnd_reg != 4'd10);
  assign nrnd      = (fsm_reg == S_INIT_ARK) ? 4'd1 : rnd_reg + 4'd1;
  assign bypass    = dec_reg ? (nrnd == 4'd1) : (nrnd == 4'd10);
  assign cin       = (fsm_reg == S_INIT_ARK) ?
                     (blk_reg ^ (dec_reg ? rk_reg[10] : rk_reg[0])) : round_res;

  round_key_tf u_key (.clk(clk), .rst_n(rst_n), .start_i(kstart), .key_i(kin),
                      .rcon_i(krcon), .done_o(kdone), .key_o(kout));
  round_tf u_enc (.clk(clk), .rst_n(rst_n), .start_i(cstart && !dec_reg), .bypass_mc(bypass),
                  .state_i(cin), .done_o(edone), .state_o(eout));
  inv_round_tf u_dec (.clk(clk), .rst_n(rst_n), .start_i(cstart && dec_reg), .bypass_mc(bypass),
                      .state_i(cin), .done_o(ddone), .state_o(dcore_out));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg    <= S_IDLE;
      dec_reg    <= 1'b0;
      cached_reg <= 1'b0;
      blk_reg    <= '0;
      dout_reg   <= '0;
      kidx_reg   <= 4'd0;
      rnd_reg    <= 4'd0;
      rcon_reg   <= 8'h00;
      for (int i = 0; i < 11; i++) rk_reg[i] <= '0;
    end else begin
      case (fsm_reg)
        S_IDLE: if (accept) begin
          dec_reg <= decrypt_i;
          blk_reg <= data_i;
          if (need_exp) begin
            rk_reg[0]  <= key_i;
            kidx_reg   <= 4'd1;
            rcon_reg   <= 8'h02;
            cached_reg <= 1'b0;
            fsm_reg    <= S_KEY_EXP;
          end else begin
            fsm_reg <= S_INIT_ARK;
          end
        end
        S_KEY_EXP: if (kdone) begin
          rk_reg[kidx_reg] <= kout;
          if (kidx_reg == 4'd10) begin
            cached_reg <= (KEY_CACHE != 0);
            fsm_reg    <= S_INIT_ARK;
          end else begin
            kidx_reg <= kidx_reg + 4'd1;
            rcon_reg <= xtime(rcon_reg);
          end
        end
        S_INIT_ARK: begin
          rnd_reg <= 4'd1;
          fsm_reg <= S_ROUND;
        end
        S_ROUND: if (cdone) begin
          if (rnd_reg == 4'd10) begin
            dout_reg <= round_res;
            fsm_reg  <= S_OUT;
          end else begin
            rnd_reg <= rnd_reg + 4'd1;
          end
        end
        S_OUT: if (out_ready_i) fsm_reg <= S_IDLE;
        default: fsm_reg <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_codec.sv
// Directed and randomized checks of aes128_codec against FIPS-197 vectors and
// a table-driven textbook AES model; latency counts the accept cycle as cycle 1.
module tb_aes128_codec;
  localparam int TK = 1;
  localparam int TR = 1;
  localparam int LAT_EXP = 10*TK + 10*TR + 3;
  localparam int LAT_CACHED = 10*TR + 3;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_valid_nc = 1'b0, decrypt = 1'b0, key_load = 1'b0, out_ready = 1'b0;
  logic [127:0] key = '0, din = '0;
  logic in_ready, out_valid, cached, in_ready_nc, out_valid_nc, cached_nc;
  logic [127:0] dout, dout_nc;

  int n_vec = 0;
  int n_err = 0;

  aes128_codec #(.KEY_CACHE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .decrypt_i(decrypt), .key_load_i(key_load), .key_i(key), .data_i(din),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .data_o(dout), .key_cached_o(cached));

  aes128_codec #(.KEY_CACHE(0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_nc), .in_ready_o(in_ready_nc),
    .decrypt_i(decrypt), .key_load_i(key_load), .key_i(key), .data_i(din),
    .out_valid_o(out_valid_nc), .out_ready_i(out_ready), .data_o(dout_nc), .key_cached_o(cached_nc));

  initial forever #5 clk = ~clk;

  // Reference model
  logic [7:0] sb [256];
  logic [7:0] isb [256];
  logic [2047:0] sbt;

  function automatic logic [7:0] m_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] m_rk(logic [127:0] k, int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = m_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] m_sub(logic [127:0] s, bit inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? isb[s[8*i +: 8]] : sb[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] m_shift(logic [127:0] s, bit inv);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c + (inv ? 4 - rw : rw)) % 4)+rw) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] m_mix(logic [127:0] s, bit inv);
    logic [127:0] r;
    logic [7:0] co [4];
    logic [7:0] acc;
    co = inv ? '{8'h0e, 8'h0b, 8'h0d, 8'h09} : '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ m_mul(s[127-8*(4*c+j) -: 8], co[(j-rw+4)%4]);
        r[127-8*(4*c+rw) -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] m_enc(logic [127:0] k, logic [127:0] p);
    logic [127:0] s;
    s = p ^ m_rk(k, 0);
    for (int r = 1; r < 10; r++) s = m_mix(m_shift(m_sub(s, 0), 0), 0) ^ m_rk(k, r);
    return m_shift(m_sub(s, 0), 0) ^ m_rk(k, 10);
  endfunction

  function automatic logic [127:0] m_dec(logic [127:0] k, logic [127:0] c);
    logic [127:0] s;
    s = c ^ m_rk(k, 10);
    for (int r = 9; r >= 1; r--) s = m_mix(m_sub(m_shift(s, 1), 1) ^ m_rk(k, r), 1);
    return m_sub(m_shift(s, 1), 1) ^ m_rk(k, 0);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction; returns the result and the cycle count from accept to out_valid
  task automatic run(input bit nc, input bit dec, input bit load, input bit hold,
                     input logic [127:0] k, input logic [127:0] d,
                     output logic [127:0] res, output int lat);
    int w;
    @(negedge clk);
    decrypt = dec; key_load = load; key = k; din = d; out_ready = !hold;
    if (nc) in_valid_nc = 1'b1; else in_valid = 1'b1;
    w = 0;
    while (!(nc ? in_ready_nc : in_ready) && w < 100) begin
      @(negedge clk);
      w++;
    end
    lat = 1;
    do begin
      @(negedge clk);
      in_valid = 1'b0; in_valid_nc = 1'b0;
      lat++;
    end while (!(nc ? out_valid_nc : out_valid) && lat < 400);
    res = nc ? dout_nc : dout;
  endtask

  initial begin
    logic [127:0] res, k, x, ct;
    int lat;
    bit ld;

    sbt = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
           128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
           128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
           128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
           128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
           128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
           128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
           128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) begin
      sb[i] = sbt[2047-8*i -: 8];
      isb[sb[i]] = i[7:0];
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_data", dout, 128'h0);
    chk("rst_cached", 128'(cached), 128'(0));
    rst_n = 1'b1;

    // FIPS-197 C.1 encrypt with key load, then cached decrypt
    run(0, 0, 1, 0, K1, P1, res, lat);
    chk("enc_k1", res, C1);
    chk("enc_k1_lat", 128'(lat), 128'(LAT_EXP));
    chk("enc_k1_cached", 128'(cached), 128'(1));
    run(0, 1, 0, 0, 128'h0, C1, res, lat);
    chk("dec_k1_cached", res, P1);
    chk("dec_k1_lat", 128'(lat), 128'(LAT_CACHED));

    // FIPS-197 B vector, with and without the cache
    run(0, 0, 1, 0, K2, P2, res, lat);
    chk("enc_k2", res, C2);
    chk("enc_k2_lat", 128'(lat), 128'(LAT_EXP));
    run(1, 0, 1, 0, K2, P2, res, lat);
    chk("nc_enc_load", res, C2);
    chk("nc_cached", 128'(cached_nc), 128'(0));
    run(1, 0, 0, 0, K2, P2, res, lat);
    chk("nc_enc_noload", res, C2);
    chk("nc_noload_lat", 128'(lat), 128'(LAT_EXP));

    // Output backpressure
    run(0, 0, 0, 1, K2, P2, res, lat);
    chk("bp_result", res, C2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold_data", dout, C2);
      chk("bp_hold_flags", {in_ready, out_valid}, 128'(2'b01));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_flags", {in_ready, out_valid}, 128'(2'b10));
    chk("bp_release_data", dout, C2);

    // Reset in the middle of ROUND
    @(negedge clk);
    decrypt = 1'b0; key_load = 1'b1; key = K1; din = P1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_data", dout, 128'h0);
    chk("mid_rst_cached", 128'(cached), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 1, 0, 0, K1, C1, res, lat);
    chk("post_rst_dec", res, P1);
    chk("post_rst_lat", 128'(lat), 128'(LAT_EXP));

    // Random blocks against the model, each encrypt followed by its decrypt
    k = K1;
    for (int i = 0; i < 100; i++) begin
      ld = (i == 0) || ($urandom_range(3) == 0);
      if (ld) k = {$urandom(), $urandom(), $urandom(), $urandom()};
      x = {$urandom(), $urandom(), $urandom(), $urandom()};
      run(0, 0, ld, 0, k, x, ct, lat);
      chk("rnd_enc", ct, m_enc(k, x));
      chk("rnd_enc_lat", 128'(lat), 128'(ld ? LAT_EXP : LAT_CACHED));
      ld = ($urandom_range(7) == 0);
      run(0, 1, ld, 0, k, ct, res, lat);
      chk("rnd_dec_model", res, m_dec(k, ct));
      chk("rnd_roundtrip", res, x);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
